// File: rtl/nibble_serial_alu_if.sv
// Request/response bundle for the nibble-serial 16-bit add/subtract engine.
// The master side issues requests and consumes results; the slave side is the engine.
interface nibble_serial_alu_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        overflow;
  logic        err;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, cout, overflow, err
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, cout, overflow, err
  );
endinterface

// File: rtl/nibble_serial_alu.sv
// 16-bit add/subtract done as four 4-bit slices, LSB first; out_valid 4 cycles after accept.
// One request in flight: in_ready is low from accept until the result is taken by out_ready.
module nibble_serial_alu (
  input  logic               clk,
  input  logic               rst_n,
  nibble_serial_alu_if.slave bus_io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } req_t;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  state_t      state_q;
  req_t        req_q;
  logic [1:0]  idx_q;
  logic        carry_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic [15:0] result_q;
  logic        cout_q;
  logic        ovf_q;
  logic        err_q;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [4:0]  slice_ext;
  logic [3:0]  slice_res_d;
  logic        slice_c_d;
  logic        legal_d;
  logic        ovf_d;

  // Bit 4 of the 5-bit slice result is the carry for add and the borrow for subtract.
  always_comb begin
    a_nib     = req_q.a[{idx_q, 2'b00} +: 4];
    b_nib     = req_q.b[{idx_q, 2'b00} +: 4];
    slice_ext = '0;
    case (req_q.op)
      OP_ADD:  slice_ext = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
      OP_SUB:  slice_ext = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, carry_q};
      default: slice_ext = '0;
    endcase
    slice_res_d = slice_ext[3:0];
    slice_c_d   = slice_ext[4];
    legal_d     = (req_q.op == OP_ADD) || (req_q.op == OP_SUB);
    ovf_d       = 1'b0;
    if (legal_d) begin
      ovf_d = ((req_q.op == OP_ADD) ? (req_q.a[15] == req_q.b[15])
                                    : (req_q.a[15] != req_q.b[15]))
              && (slice_res_d[3] != req_q.a[15]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.in_valid && in_ready_q) begin
            req_q.op   <= bus_io.op;
            req_q.a    <= bus_io.a;
            req_q.b    <= bus_io.b;
            carry_q    <= bus_io.cin;
            idx_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          result_q[{idx_q, 2'b00} +: 4] <= slice_res_d;
          carry_q <= slice_c_d;
          idx_q   <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            cout_q      <= slice_c_d;
            ovf_q       <= ovf_d;
            err_q       <= !legal_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.result    = result_q;
  assign bus_io.cout      = cout_q;
  assign bus_io.overflow  = ovf_q;
  assign bus_io.err       = err_q;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Bench for nibble_serial_alu: directed vectors, randomized ops against a 16-bit arithmetic model,
// backpressure, back-to-back throughput and asynchronous reset in the middle of a request.
module tb_nibble_serial_alu;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;

  nibble_serial_alu_if bus ();

  nibble_serial_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Whole-word reference: {result, cout, overflow, err}.
  function automatic logic [18:0] model(input logic [1:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    if (op == 2'b01) begin
      s = {1'b0, a} + {1'b0, b} + 17'(cin);
      r = s[15:0];
      c = s[16];
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end else if (op == 2'b10) begin
      r = a - b - 16'(cin);
      c = ({1'b0, a} < ({1'b0, b} + 17'(cin)));
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      return {16'h0000, 3'b001};
    end
    return {r, c, v, 1'b0};
  endfunction

  // Issues one request at the current negedge and returns what was observed.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int hold,
                        output int lat, output logic [18:0] obs, output logic busy_rdy,
                        output logic rdy_after, output logic vld_after, output int acc_cyc);
    bus.in_valid = 1'b1;
    bus.op  = op;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    @(negedge clk);
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.op  = 2'($urandom);
    bus.a   = 16'($urandom);
    bus.b   = 16'($urandom);
    bus.cin = 1'($urandom);
    busy_rdy = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      busy_rdy = busy_rdy | bus.in_ready;
      @(negedge clk);
      lat++;
    end
    busy_rdy = busy_rdy | bus.in_ready;
    obs = {bus.result, bus.cout, bus.overflow, bus.err};
    repeat (hold) @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    rdy_after = bus.in_ready;
    vld_after = bus.out_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_handshake got=%b want=10", {bus.in_ready, bus.out_valid});
    end
    total++;
    if ({bus.result, bus.cout, bus.overflow, bus.err} !== 19'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", {bus.result, bus.cout, bus.overflow, bus.err});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [9] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b00, 2'b10};
    logic [15:0] t_a  [9] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0010,
                             16'hAAAA, 16'h1234, 16'h0000};
    logic [15:0] t_b  [9] = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0000,
                             16'h5555, 16'h0001, 16'h0000};
    logic        t_ci [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [18:0] t_ex [9] = '{{16'h2233, 3'b000}, {16'h0000, 3'b100}, {16'h8000, 3'b010},
                             {16'hFFFE, 3'b100}, {16'h7FFF, 3'b010}, {16'h000F, 3'b000},
                             {16'h0000, 3'b001}, {16'h0000, 3'b001}, {16'hFFFF, 3'b100}};
    int lat, acc;
    logic [18:0] obs;
    logic busy, rdy, vld;
    for (int i = 0; i < 9; i++) begin
      run_op(t_op[i], t_a[i], t_b[i], t_ci[i], 0, lat, obs, busy, rdy, vld, acc);
      total++;
      if (obs !== t_ex[i]) begin
        bad++;
        $display("FAIL directed_%0d got=%h want=%h", i, obs, t_ex[i]);
      end
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL directed_latency_%0d got=%0d want=4", i, lat);
      end
      total++;
      if ({busy, rdy, vld} !== 3'b010) begin
        bad++;
        $display("FAIL directed_handshake_%0d got=%b want=010", i, {busy, rdy, vld});
      end
    end
  endtask

  task automatic test_random();
    int lat, acc;
    logic [18:0] obs, exp_v;
    logic busy, rdy, vld;
    logic [1:0] op;
    logic [15:0] a, b;
    logic ci;
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 2'($urandom) : (($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10);
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      exp_v = model(op, a, b, ci);
      run_op(op, a, b, ci, $urandom_range(0, 3), lat, obs, busy, rdy, vld, acc);
      total++;
      if (obs !== exp_v || lat !== 4) begin
        bad++;
        $display("FAIL random_%0d op=%b a=%h b=%h cin=%b got=%h lat=%0d want=%h lat=4",
                 i, op, a, b, ci, obs, lat, exp_v);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [18:0] exp_v;
    int lat;
    exp_v = model(2'b01, 16'h4321, 16'h1111, 1'b0);
    bus.in_valid = 1'b1; bus.op = 2'b01; bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b0;
    @(negedge clk);
    // Keep offering a different request through RUN and DONE; it must be ignored.
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1; bus.op = 2'b10;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL bp_latency got=%0d want=4", lat);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.overflow, bus.err}
          !== {2'b10, exp_v}) begin
        bad++;
        $display("FAIL bp_hold_%0d got=%h want=%h", i,
                 {bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.overflow, bus.err},
                 {2'b10, exp_v});
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release got=%b want=10", {bus.in_ready, bus.out_valid});
    end
    @(negedge clk);
    total++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_nothing_queued got=%b want=10", {bus.in_ready, bus.out_valid});
    end
  endtask

  task automatic test_back_to_back();
    int lat, acc0, acc1;
    logic [18:0] obs0, obs1;
    logic busy, rdy, vld;
    run_op(2'b01, 16'h00F0, 16'h0F10, 1'b1, 0, lat, obs0, busy, rdy, vld, acc0);
    run_op(2'b10, 16'h0100, 16'h0001, 1'b0, 0, lat, obs1, busy, rdy, vld, acc1);
    total++;
    if (acc1 - acc0 !== 6) begin
      bad++;
      $display("FAIL b2b_period got=%0d want=6", acc1 - acc0);
    end
    total++;
    if ({obs0, obs1} !== {model(2'b01, 16'h00F0, 16'h0F10, 1'b1), model(2'b10, 16'h0100, 16'h0001, 1'b0)}) begin
      bad++;
      $display("FAIL b2b_results got=%h_%h want=%h_%h", obs0, obs1,
               model(2'b01, 16'h00F0, 16'h0F10, 1'b1), model(2'b10, 16'h0100, 16'h0001, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    int lat, acc;
    logic [18:0] obs;
    logic busy, rdy, vld;
    bus.in_valid = 1'b1; bus.op = 2'b01; bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    // Slices 0 and 1 are written; slice 2 is being computed.
    rst_n = 1'b0;
    #2;
    total++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b01, 16'h0000}) begin
      bad++;
      $display("FAIL reset_mid got=%h want=%h", {bus.out_valid, bus.in_ready, bus.result},
               {2'b01, 16'h0000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(2'b01, 16'h0001, 16'h0001, 1'b0, 0, lat, obs, busy, rdy, vld, acc);
    total++;
    if (obs !== {16'h0002, 3'b000} || lat !== 4) begin
      bad++;
      $display("FAIL reset_mid_recover got=%h lat=%0d want=%h lat=4", obs, lat, {16'h0002, 3'b000});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
